pc_unit: RTL and testbench
==========================

# pc_unit

Parametrised program-counter unit for the multicycle/pipelined MIPS core; successor to the single-width fixed-vector PC register. Holds the fetch address and selects the next PC from sequential, branch, jump, register-jump, exception and exception-return sources under a fixed priority. An optional return-address stack predicts `jr $ra` targets. It sits between the control unit and instruction memory, and its `pc` output drives the fetch address.

## Interface
Parameters:
- ADDR_W, 32, PC width; legal range 28..32.
- RESET_VEC, 32'h0000_3000, PC value after reset, truncated to ADDR_W.
- EXC_VEC, 32'h0000_4180, exception handler entry, truncated to ADDR_W.
- RAS_DEPTH, 4, return-address stack entries; power of two, minimum 2.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- pc_wr  in  1  update enable; 0 holds the PC (stall), except on exc/eret.
- br_taken  in  1  conditional branch resolved taken.
- br_off  in  16  signed word offset of the branch.
- jump  in  1  j/jal absolute jump.
- jump_adr  in  26  instr_index field of the jump instruction.
- call  in  1  jal/jalr; pushes the return address (with RAS_EN).
- jr  in  1  register jump.
- jr_adr  in  ADDR_W  register jump target.
- ret  in  1  qualifies jr as a return (`jr $ra`).
- exc  in  1  exception taken.
- eret  in  1  return from exception.
- pc  out  ADDR_W  registered current PC.
- npc  out  ADDR_W  combinational next PC, as selected by the current inputs.
- epc  out  ADDR_W  registered exception PC.
- ras_cnt  out  $clog2(RAS_DEPTH)+1  number of valid stack entries.

## Operation
- seq = pc + 4, modulo 2^ADDR_W; wrap from all-ones to 0 is legal.
- Branch target: seq + (sext(br_off) << 2), modulo 2^ADDR_W.
- Jump target: {seq[ADDR_W-1:28], jump_adr, 2'b00}. When ADDR_W == 28 there is no upper field.
- jr target: jr_adr with bits [1:0] forced to 0.
- npc priority, highest first:
  - exc → EXC_VEC
  - eret → epc
  - pc_wr == 0 → pc
  - jr → jr target, or the stack top if ret, RAS_EN is defined and ras_cnt > 0
  - jump → jump target
  - br_taken → branch target
  - otherwise → seq
- On each clock, pc <= npc.
- exc: epc <= pc, regardless of pc_wr. If exc and eret are both asserted, exc wins and epc is overwritten.
- Return-address stack, active only with RAS_EN:
  - Circular LIFO of RAS_DEPTH entries.
  - An op is accepted only when pc_wr = 1, exc = 0 and eret = 0.
  - call accepted: push seq.
  - ret with jr accepted and ras_cnt > 0: pop.
  - Push when full overwrites the oldest entry; ras_cnt saturates at RAS_DEPTH.
  - Pop when empty has no effect, and the target comes from jr_adr.
  - call and ret in the same cycle (jalr $ra): pop then push. The target is the old top, the new top is seq, and ras_cnt is unchanged.
  - The stack is never flushed by exc or eret.

## Timing
- Reset values:
  - pc = RESET_VEC
  - epc = 0
  - ras_cnt = 0; stack contents are don't-care
  - npc follows the inputs combinationally
- rst takes priority over every other input in the same cycle.
- Redirect latency is 1 cycle: a source asserted in cycle n gives pc = target in cycle n+1.
- Stall: while pc_wr = 0, pc, ras_cnt and the stack are held. exc and eret still redirect.
- Reset during an active stall or redirect: the next pc is RESET_VEC and any push/pop is discarded.
- No input handshake. Decode guarantees that at most one of br_taken, jump and jr is asserted. If more than one is asserted, the priority above still decides.

## Configuration
- RAS_EN defined:
  - Stack instantiated.
  - ret with jr uses the stack top when ras_cnt > 0.
- RAS_EN undefined:
  - No stack storage.
  - ras_cnt tied to 0.
  - ret is ignored, so jr always targets jr_adr.
  - call behaves as a plain jump or jr.

## Structure
- Shared package `pc_pkg`:
  - default RESET_VEC and EXC_VEC
  - `pc_sel_e` enum {SEL_EXC, SEL_ERET, SEL_HOLD, SEL_JR, SEL_J, SEL_BR, SEL_SEQ}
  - the function computing jump_target
- One sub-module, `ras_stack`: circular LIFO with parameter DEPTH, push/pop/top/cnt. It is instantiated only under RAS_EN.

## Test plan
- Reset, then 3 cycles with pc_wr=1 → pc = 0x3000, 0x3004, 0x3008, 0x300C.
- pc=0x3010, br_taken=1, br_off=16'hFFFC → next pc = 0x3004. Then jump=1, jump_adr=26'h0000C40 → next pc = 0x0000_3100.
- pc_wr=0 for 2 cycles with br_taken=1 → pc held. Then exc=1 with pc_wr=0 at pc=0x3020 → pc = EXC_VEC, epc = 0x3020. Then eret=1 → pc = 0x3020.
- RAS_EN, RAS_DEPTH=4:
  - call at pc = 0x3000, 0x3100, 0x3200, 0x3300, 0x3400 (5 pushes) → ras_cnt = 4.
  - Then 4 × (jr+ret) → targets 0x3404, 0x3304, 0x3204, 0x3104.
  - A 5th ret with jr_adr=0x3500 → target 0x3500, ras_cnt stays 0.
- RAS_EN: call+jr+ret together at pc 0x3040 with top = 0x3104 → pc = 0x3104, top = 0x3044, ras_cnt unchanged. Then rst mid-sequence → pc = 0x3000, ras_cnt = 0.
- ADDR_W=32, pc=32'hFFFF_FFFC sequential → pc = 0. Then jr_adr=0x3007 → pc = 0x3004.

Source files
------------

// File: rtl/pc_pkg.sv
// pc_pkg: shared definitions for the program-counter unit.
//   DEF_RESET_VEC / DEF_EXC_VEC : default reset and exception vectors (32-bit,
//                                 truncated to ADDR_W by the user).
//   pc_sel_e                    : next-PC source, listed in priority order.
//   jump_target()               : j/jal target from the sequential PC and the
//                                 26-bit instr_index field.
package pc_pkg;

  localparam logic [31:0] DEF_RESET_VEC = 32'h0000_3000;
  localparam logic [31:0] DEF_EXC_VEC   = 32'h0000_4180;

  typedef enum logic [2:0] {
    SEL_EXC,
    SEL_ERET,
    SEL_HOLD,
    SEL_JR,
    SEL_J,
    SEL_BR,
    SEL_SEQ
  } pc_sel_e;

  // Computed at full 32-bit width; callers zero-extend seq and truncate the
  // result, so a 28-bit PC simply loses the (zero) upper field.
  function automatic logic [31:0] jump_target(input logic [31:0] seq,
                                              input logic [25:0] idx);
    return {seq[31:28], idx, 2'b00};
  endfunction

endpackage

// File: rtl/pc_unit_ras_stack.sv
// ras_stack: circular LIFO of return addresses.
//   clk, rst : clock, synchronous active-high reset (clears pointer and count)
//   push     : write din as the new top
//   pop      : drop the current top (ignored when empty)
//   din      : address to push
//   top      : current top entry (meaningless when cnt == 0)
//   cnt      : number of valid entries, saturating at DEPTH
// Pushing when full overwrites the oldest entry because the pointer wraps.
// push and pop together replace the top in place (count unchanged).
module ras_stack #(
  parameter int DEPTH = 4,
  parameter int W     = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [W-1:0]           din,
  output logic [W-1:0]           top,
  output logic [$clog2(DEPTH):0] cnt
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] ptr;
  logic [PW-1:0] wr_idx;
  logic          has_top;

  assign has_top = (cnt != '0);
  assign top     = mem[ptr];
  // Pop+push overwrites the current top slot; a plain push goes one above it.
  assign wr_idx  = (pop && has_top) ? ptr : ptr + PW'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
      cnt <= '0;
    end else begin
      unique case ({push, pop})
        2'b10: begin
          ptr <= ptr + PW'(1);
          if (cnt != FULL) cnt <= cnt + 1'b1;
        end
        2'b01: begin
          if (has_top) begin
            ptr <= ptr - PW'(1);
            cnt <= cnt - 1'b1;
          end
        end
        2'b11: begin
          // Empty pop is a no-op, leaving a plain push.
          if (!has_top) begin
            ptr <= ptr + PW'(1);
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Storage carries no reset; contents are only meaningful while cnt > 0.
  always_ff @(posedge clk) begin
    if (push && !rst) mem[wr_idx] <= din;
  end

endmodule

// File: rtl/pc_unit.sv
// pc_unit: program counter with fixed-priority next-PC selection.
//   Sources (highest first): exc, eret, stall hold, jr, jump, branch, pc+4.
//   Optional return-address stack predicting `jr $ra`, enabled by defining
//   the macro RAS_EN. Without it, ras_cnt is 0, ret is ignored and call has
//   no side effect.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   pc_wr           : update enable (0 = stall; exc/eret still redirect)
//   br_taken,br_off : taken branch and its signed word offset
//   jump, jump_adr  : j/jal and its instr_index field
//   call            : jal/jalr, pushes the return address
//   jr, jr_adr, ret : register jump, its target, and return qualifier
//   exc, eret       : exception entry / return
//   pc, epc         : registered PC and exception PC
//   npc             : combinational next PC
//   ras_cnt         : valid return-stack entries
module pc_unit
  import pc_pkg::*;
#(
  parameter int          ADDR_W    = 32,
  parameter logic [31:0] RESET_VEC = DEF_RESET_VEC,
  parameter logic [31:0] EXC_VEC   = DEF_EXC_VEC,
  parameter int          RAS_DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       pc_wr,
  input  logic                       br_taken,
  input  logic [15:0]                br_off,
  input  logic                       jump,
  input  logic [25:0]                jump_adr,
  input  logic                       call,
  input  logic                       jr,
  input  logic [ADDR_W-1:0]          jr_adr,
  input  logic                       ret,
  input  logic                       exc,
  input  logic                       eret,
  output logic [ADDR_W-1:0]          pc,
  output logic [ADDR_W-1:0]          npc,
  output logic [ADDR_W-1:0]          epc,
  output logic [$clog2(RAS_DEPTH):0] ras_cnt
);

  logic [ADDR_W-1:0] seq;
  logic [ADDR_W-1:0] br_tgt;
  logic [ADDR_W-1:0] j_tgt;
  logic [ADDR_W-1:0] jr_tgt;
  logic [ADDR_W-1:0] ras_top;
  logic [ADDR_W-1:0] off_ext;
  logic [31:0]       seq32;
  logic [31:0]       jt32;
  logic              use_ras;
  pc_sel_e           sel;

  assign seq     = pc + ADDR_W'(4);
  // Sign-extended word offset already scaled by 4.
  assign off_ext = {{(ADDR_W-18){br_off[15]}}, br_off, 2'b00};
  assign br_tgt  = seq + off_ext;
  assign jr_tgt  = {jr_adr[ADDR_W-1:2], 2'b00};

  always_comb begin
    seq32             = '0;
    seq32[ADDR_W-1:0] = seq;
    jt32              = jump_target(seq32, jump_adr);
  end
  assign j_tgt = jt32[ADDR_W-1:0];

  logic unused_jr;
  assign unused_jr = ^jr_adr[1:0];

`ifdef RAS_EN
  logic accept;
  logic ras_push;
  logic ras_pop;

  // Stack ops only take effect on a real, non-exceptional PC update.
  assign accept   = pc_wr & ~exc & ~eret;
  assign ras_push = accept & call;
  assign ras_pop  = accept & jr & ret & (ras_cnt != '0);
  assign use_ras  = ret & (ras_cnt != '0);

  ras_stack #(
    .DEPTH (RAS_DEPTH),
    .W     (ADDR_W)
  ) u_ras (
    .clk  (clk),
    .rst  (rst),
    .push (ras_push),
    .pop  (ras_pop),
    .din  (seq),
    .top  (ras_top),
    .cnt  (ras_cnt)
  );
`else
  assign ras_cnt = '0;
  assign use_ras = 1'b0;
  assign ras_top = '0;

  logic unused_ras;
  assign unused_ras = ^{call, ret};
`endif

  always_comb begin
    sel = SEL_SEQ;
    if (exc)           sel = SEL_EXC;
    else if (eret)     sel = SEL_ERET;
    else if (!pc_wr)   sel = SEL_HOLD;
    else if (jr)       sel = SEL_JR;
    else if (jump)     sel = SEL_J;
    else if (br_taken) sel = SEL_BR;
  end

  always_comb begin
    npc = seq;
    unique case (sel)
      SEL_EXC:  npc = EXC_VEC[ADDR_W-1:0];
      SEL_ERET: npc = epc;
      SEL_HOLD: npc = pc;
      SEL_JR:   npc = use_ras ? ras_top : jr_tgt;
      SEL_J:    npc = j_tgt;
      SEL_BR:   npc = br_tgt;
      default:  npc = seq;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc  <= RESET_VEC[ADDR_W-1:0];
      epc <= '0;
    end else begin
      pc <= npc;
      if (exc) epc <= pc;
    end
  end

endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: directed-vector bench for pc_unit (default parameters).
// Stimulus pushes the expected post-edge pc/epc/ras_cnt into a queue; a
// monitor pops one entry after each rising edge and compares.
module tb_pc_unit;

  logic        clk = 1'b0;
  logic        rst, pc_wr, br_taken, jump, call, jr, ret, exc, eret;
  logic [15:0] br_off;
  logic [25:0] jump_adr;
  logic [31:0] jr_adr;
  logic [31:0] pc, npc, epc;
  logic [2:0]  ras_cnt;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string       nm;
    logic [31:0] pc;
    logic [31:0] epc;
    int          cnt;
  } exp_t;

  exp_t q[$];

  always #5 clk = ~clk;

  pc_unit dut (
    .clk      (clk),
    .rst      (rst),
    .pc_wr    (pc_wr),
    .br_taken (br_taken),
    .br_off   (br_off),
    .jump     (jump),
    .jump_adr (jump_adr),
    .call     (call),
    .jr       (jr),
    .jr_adr   (jr_adr),
    .ret      (ret),
    .exc      (exc),
    .eret     (eret),
    .pc       (pc),
    .npc      (npc),
    .epc      (epc),
    .ras_cnt  (ras_cnt)
  );

  task automatic chk(input string nm, input string fld,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s.%s: got %h expected %h", nm, fld, act, exp);
    end
  endtask

  // Monitor: one expectation per rising edge that has one queued.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk(e.nm, "pc", pc, e.pc);
        chk(e.nm, "epc", epc, e.epc);
        chk(e.nm, "ras_cnt", 32'(ras_cnt), 32'(e.cnt));
      end
    end
  end

  task automatic clr();
    rst = 0; pc_wr = 1; br_taken = 0; br_off = '0; jump = 0; jump_adr = '0;
    call = 0; jr = 0; jr_adr = '0; ret = 0; exc = 0; eret = 0;
  endtask

  task automatic step(input string nm, input logic [31:0] e_pc,
                      input logic [31:0] e_epc, input int e_cnt);
    exp_t e;
    e.nm = nm; e.pc = e_pc; e.epc = e_epc; e.cnt = e_cnt;
    q.push_back(e);
    @(negedge clk);
  endtask

  initial begin
    clr();
    rst = 1; br_taken = 1; br_off = 16'h0010;
    step("reset", 32'h3000, 32'h0, 0);

    clr();
    step("seq1", 32'h3004, 0, 0);
    step("seq2", 32'h3008, 0, 0);
    step("seq3", 32'h300C, 0, 0);
    step("seq4", 32'h3010, 0, 0);

    clr(); br_taken = 1; br_off = 16'hFFFC;
    step("br_back", 32'h3004, 0, 0);
    clr(); jump = 1; jump_adr = 26'h0000C40;
    step("jump", 32'h3100, 0, 0);
    clr(); jr = 1; jr_adr = 32'h3018;
    step("jr", 32'h3018, 0, 0);
    clr();
    step("seq5", 32'h301C, 0, 0);
    step("seq6", 32'h3020, 0, 0);

    clr(); pc_wr = 0; br_taken = 1; br_off = 16'h0100;
    step("stall1", 32'h3020, 0, 0);
    step("stall2", 32'h3020, 0, 0);
    exc = 1;
    step("exc_stall", 32'h4180, 32'h3020, 0);
    clr(); pc_wr = 0; eret = 1;
    step("eret", 32'h3020, 32'h3020, 0);
    clr();
    step("seq7", 32'h3024, 32'h3020, 0);
    exc = 1; eret = 1;
    step("exc_eret", 32'h4180, 32'h3024, 0);
    clr(); eret = 1;
    step("eret2", 32'h3024, 32'h3024, 0);

    clr(); jr = 1; jr_adr = 32'hFFFF_FFFC;
    step("jr_top", 32'hFFFF_FFFC, 32'h3024, 0);
    clr();
    step("wrap", 32'h0, 32'h3024, 0);
    clr(); jr = 1; jr_adr = 32'h3007;
    step("jr_align", 32'h3004, 32'h3024, 0);

`ifdef RAS_EN
    clr(); jr = 1; jr_adr = 32'h3000;
    step("ras_goto", 32'h3000, 32'h3024, 0);
    clr(); call = 1; jump = 1;
    jump_adr = 26'hC40; step("push1", 32'h3100, 32'h3024, 1);
    jump_adr = 26'hC80; step("push2", 32'h3200, 32'h3024, 2);
    jump_adr = 26'hCC0; step("push3", 32'h3300, 32'h3024, 3);
    jump_adr = 26'hD00; step("push4", 32'h3400, 32'h3024, 4);
    jump_adr = 26'hD40; step("push5_full", 32'h3500, 32'h3024, 4);
    clr(); jr = 1; ret = 1; jr_adr = 32'h0;
    step("pop1", 32'h3404, 32'h3024, 3);
    step("pop2", 32'h3304, 32'h3024, 2);
    step("pop3", 32'h3204, 32'h3024, 1);
    step("pop4", 32'h3104, 32'h3024, 0);
    jr_adr = 32'h3500;
    step("pop_empty", 32'h3500, 32'h3024, 0);
    clr(); jr = 1; jr_adr = 32'h3100;
    step("goto3100", 32'h3100, 32'h3024, 0);
    clr(); call = 1; jump = 1; jump_adr = 26'hC10;
    step("push_3104", 32'h3040, 32'h3024, 1);
    clr(); call = 1; jr = 1; ret = 1; jr_adr = 32'h0;
    step("jalr_ra", 32'h3104, 32'h3024, 1);
    clr(); jr = 1; ret = 1; jr_adr = 32'h0;
    step("pop_new_top", 32'h3044, 32'h3024, 0);
    clr(); call = 1; jump = 1; jump_adr = 26'hC40;
    step("push_3048", 32'h3100, 32'h3024, 1);
    clr(); pc_wr = 0; call = 1; jr = 1; ret = 1;
    step("stall_ras", 32'h3100, 32'h3024, 1);
    clr(); exc = 1; call = 1;
    step("exc_no_push", 32'h4180, 32'h3100, 1);
    clr(); rst = 1; call = 1; jump = 1; jump_adr = 26'hD00;
    step("rst_mid", 32'h3000, 32'h0, 0);
`else
    clr(); call = 1; jr = 1; ret = 1; jr_adr = 32'h3200;
    step("ret_ignored", 32'h3200, 32'h3024, 0);
    clr(); call = 1; jump = 1; jump_adr = 26'hC40;
    step("call_jump", 32'h3100, 32'h3024, 0);
    clr(); rst = 1; call = 1; exc = 1;
    step("rst_mid", 32'h3000, 32'h0, 0);
`endif

    clr();
    for (int i = 0; i < 5 && q.size() > 0; i++) @(posedge clk);
    #2;
    if (q.size() > 0) begin
      failures++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
